// File: rtl/bitcoin_pkg.sv
// Shared widths and FSM state type for the bitcoin miner host-side job dispatcher.
package bitcoin_pkg;

   localparam int HEADER_W = 608;
   localparam int TARGET_W = 8;
   localparam int NONCE_W  = 32;
   localparam int DIGEST_W = 256;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } disp_state_e;

endpackage

// File: rtl/bitcoin_job_dispatcher_if.sv
// Bundles the job stream, miner request/result handshakes and result stream of the dispatcher.
interface bitcoin_job_dispatcher_if
   import bitcoin_pkg::*;
#(
   parameter int ID_W  = 8,
   parameter int CNT_W = 32
);

   logic                job_val;
   logic                job_rdy;
   logic [HEADER_W-1:0] job_header;
   logic [TARGET_W-1:0] job_target;
   logic [ID_W-1:0]     job_id;

   logic [HEADER_W-1:0] block_header;
   logic [TARGET_W-1:0] hash_target;
   logic                req_val;
   logic                req_rdy;
   logic [NONCE_W-1:0]  golden_nonce;
   logic [DIGEST_W-1:0] golden_digest;
   logic                golden_nonce_val;
   logic                golden_nonce_rdy;

   logic                res_val;
   logic                res_rdy;
   logic [ID_W-1:0]     res_id;
   logic [NONCE_W-1:0]  res_nonce;
   logic [DIGEST_W-1:0] res_digest;
   logic [CNT_W-1:0]    res_cycles;

   logic                busy;
   logic [CNT_W-1:0]    jobs_done;

   // Dispatcher side
   modport master (
      input  job_val, job_header, job_target, job_id,
      input  req_rdy, golden_nonce, golden_digest, golden_nonce_val,
      input  res_rdy,
      output job_rdy, block_header, hash_target, req_val, golden_nonce_rdy,
      output res_val, res_id, res_nonce, res_digest, res_cycles,
      output busy, jobs_done
   );

   // Host queue / miner side
   modport slave (
      output job_val, job_header, job_target, job_id,
      output req_rdy, golden_nonce, golden_digest, golden_nonce_val,
      output res_rdy,
      input  job_rdy, block_header, hash_target, req_val, golden_nonce_rdy,
      input  res_val, res_id, res_nonce, res_digest, res_cycles,
      input  busy, jobs_done
   );

endinterface

// File: rtl/bitcoin_job_dispatcher.sv
// Keeps one job in flight in a single miner plus one buffered job, and returns
// each golden nonce tagged with its job id and measured miner latency.
module bitcoin_job_dispatcher
   import bitcoin_pkg::*;
#(
   parameter int ID_W  = 8,
   parameter int CNT_W = 32
)
(
   input  logic                     clk,
   input  logic                     rst,
   bitcoin_job_dispatcher_if.master bus
);

   disp_state_e r_state;
   disp_state_e w_nextState;

   logic                r_bufValid;
   logic [HEADER_W-1:0] r_bufHeader;
   logic [TARGET_W-1:0] r_bufTarget;
   logic [ID_W-1:0]     r_bufId;

   logic [HEADER_W-1:0] r_blockHeader;
   logic [TARGET_W-1:0] r_hashTarget;
   logic [ID_W-1:0]     r_curId;

   logic [CNT_W-1:0]    r_latency;
   logic [ID_W-1:0]     r_resId;
   logic [NONCE_W-1:0]  r_resNonce;
   logic [DIGEST_W-1:0] r_resDigest;
   logic [CNT_W-1:0]    r_resCycles;
   logic [CNT_W-1:0]    r_jobsDone;

   logic             w_jobAccept;
   logic             w_load;
   logic             w_clearCount;
   logic             w_capture;
   logic             w_resDone;
   logic             w_reqVal;
   logic             w_gnRdy;
   logic             w_resVal;
   logic [CNT_W-1:0] w_latencyInc;

   assign w_jobAccept  = bus.job_val && !r_bufValid;
   assign w_latencyInc = (r_latency == '1) ? r_latency : r_latency + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState  = r_state;
      w_load       = 1'b0;
      w_clearCount = 1'b0;
      w_capture    = 1'b0;
      w_resDone    = 1'b0;
      w_reqVal     = 1'b0;
      w_gnRdy      = 1'b0;
      w_resVal     = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_bufValid) begin
               w_load      = 1'b1;
               w_nextState = ISSUE;
            end
         end
         ISSUE: begin
            w_reqVal = 1'b1;
            if (bus.req_rdy) begin
               w_clearCount = 1'b1;
               w_nextState  = WAIT;
            end
         end
         WAIT: begin
            w_gnRdy = 1'b1;
            if (bus.golden_nonce_val) begin
               w_capture   = 1'b1;
               w_nextState = RESP;
            end
         end
         RESP: begin
            w_resVal = 1'b1;
            if (bus.res_rdy) begin
               w_resDone = 1'b1;
               // A waiting job goes straight back to the miner, skipping IDLE
               if (r_bufValid) begin
                  w_load      = 1'b1;
                  w_nextState = ISSUE;
               end else begin
                  w_nextState = IDLE;
               end
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bufValid <= 1'b0;
      end else if (w_jobAccept) begin
         r_bufValid <= 1'b1;
      end else if (w_load) begin
         r_bufValid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_jobAccept) begin
         r_bufHeader <= bus.job_header;
         r_bufTarget <= bus.job_target;
         r_bufId     <= bus.job_id;
      end
   end

   // Miner inputs only move on a buffer load, so they stay stable through ISSUE and WAIT
   always_ff @(posedge clk) begin
      if (rst) begin
         r_blockHeader <= '0;
         r_hashTarget  <= '0;
         r_curId       <= '0;
      end else if (w_load) begin
         r_blockHeader <= r_bufHeader;
         r_hashTarget  <= r_bufTarget;
         r_curId       <= r_bufId;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_latency <= '0;
      end else if (w_clearCount) begin
         r_latency <= '0;
      end else if (r_state == WAIT) begin
         r_latency <= w_latencyInc;
      end
   end

   // The counter lags the nonce handshake by one, hence the +1 at capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_resId     <= '0;
         r_resNonce  <= '0;
         r_resDigest <= '0;
         r_resCycles <= '0;
      end else if (w_capture) begin
         r_resId     <= r_curId;
         r_resNonce  <= bus.golden_nonce;
         r_resDigest <= bus.golden_digest;
         r_resCycles <= w_latencyInc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_jobsDone <= '0;
      end else if (w_resDone) begin
         r_jobsDone <= r_jobsDone + CNT_W'(1);
      end
   end

   assign bus.job_rdy          = !r_bufValid;
   assign bus.block_header     = r_blockHeader;
   assign bus.hash_target      = r_hashTarget;
   assign bus.req_val          = w_reqVal;
   assign bus.golden_nonce_rdy = w_gnRdy;
   assign bus.res_val          = w_resVal;
   assign bus.res_id           = r_resId;
   assign bus.res_nonce        = r_resNonce;
   assign bus.res_digest       = r_resDigest;
   assign bus.res_cycles       = r_resCycles;
   assign bus.busy             = (r_state != IDLE) || r_bufValid;
   assign bus.jobs_done        = r_jobsDone;

endmodule

// File: tb/tb_bitcoin_job_dispatcher.sv
// Directed bench for bitcoin_job_dispatcher with a behavioural miner model whose
// response delay, req_rdy stall and returned nonce are set per test.
module tb_bitcoin_job_dispatcher;
   import bitcoin_pkg::*;

   localparam int ID_W  = 8;
   localparam int CNT_W = 32;

   typedef struct {
      logic [HEADER_W-1:0] header;
      logic [TARGET_W-1:0] target;
      logic [ID_W-1:0]     id;
   } job_t;

   typedef struct {
      int                  edgeNum;
      logic [ID_W-1:0]     id;
      logic [NONCE_W-1:0]  nonce;
      logic [DIGEST_W-1:0] digest;
      logic [CNT_W-1:0]    cycles;
   } res_t;

   typedef struct {
      int                  edgeNum;
      logic [HEADER_W-1:0] header;
      logic [TARGET_W-1:0] target;
   } req_t;

   logic clk = 1'b0;
   logic rst;

   job_t jobQ[$];
   res_t resLog[$];
   req_t reqLog[$];
   int   acceptLog[$];
   int   gnLog[$];

   int          edgeCnt = 0;
   int          checks;
   int          failures;
   int          mDelay;
   int          mStall;
   logic [31:0] mNonce;
   logic        tLateGnv;

   res_t monRes;
   req_t monReq;

   always #5 clk = ~clk;

   bitcoin_job_dispatcher_if #(.ID_W(ID_W), .CNT_W(CNT_W)) bus ();

   bitcoin_job_dispatcher #(.ID_W(ID_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always @(posedge clk) edgeCnt++;

   // Handshakes are logged at the negedge before the edge on which they complete
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.job_val && bus.job_rdy) acceptLog.push_back(edgeCnt + 1);
         if (bus.golden_nonce_val && bus.golden_nonce_rdy) gnLog.push_back(edgeCnt + 1);
         if (bus.req_val && bus.req_rdy) begin
            monReq.edgeNum = edgeCnt + 1;
            monReq.header  = bus.block_header;
            monReq.target  = bus.hash_target;
            reqLog.push_back(monReq);
         end
         if (bus.res_val && bus.res_rdy) begin
            monRes.edgeNum = edgeCnt + 1;
            monRes.id      = bus.res_id;
            monRes.nonce   = bus.res_nonce;
            monRes.digest  = bus.res_digest;
            monRes.cycles  = bus.res_cycles;
            resLog.push_back(monRes);
         end
      end
   end

   // Behavioural miner: digest has exactly 'target' leading zero bits
   initial begin : minerModel
      logic       reqFire, gnFire, rstNow, pend, mGnv;
      logic [7:0] tgt, tgtSample;
      int         cnt, stallSeen;
      bus.req_rdy = 1'b0;
      bus.golden_nonce_val = 1'b0;
      bus.golden_nonce = '0;
      bus.golden_digest = '0;
      pend = 1'b0;
      mGnv = 1'b0;
      tgt = '0;
      cnt = 0;
      stallSeen = 0;
      forever begin
         @(negedge clk);
         rstNow    = rst;
         reqFire   = bus.req_val && bus.req_rdy;
         gnFire    = bus.golden_nonce_val && bus.golden_nonce_rdy;
         tgtSample = bus.hash_target;
         if (bus.req_val && !bus.req_rdy) stallSeen++;
         @(posedge clk);
         #1;
         if (rstNow) begin
            pend = 1'b0;
            mGnv = 1'b0;
            stallSeen = 0;
         end else begin
            if (gnFire) mGnv = 1'b0;
            if (reqFire) begin
               stallSeen = 0;
               tgt = tgtSample;
               cnt = mDelay - 1;
               pend = (cnt > 0);
               if (cnt <= 0) mGnv = 1'b1;
            end else if (pend) begin
               cnt--;
               if (cnt <= 0) begin
                  mGnv = 1'b1;
                  pend = 1'b0;
               end
            end
         end
         bus.req_rdy = (stallSeen >= mStall);
         bus.golden_nonce_val = mGnv | tLateGnv;
         bus.golden_nonce = mNonce;
         bus.golden_digest = 256'h1 << (255 - int'(tgt));
      end
   end

   initial begin : jobDriver
      logic accepted;
      bus.job_val = 1'b0;
      bus.job_header = '0;
      bus.job_target = '0;
      bus.job_id = '0;
      forever begin
         @(negedge clk);
         accepted = bus.job_val && bus.job_rdy && !rst;
         @(posedge clk);
         #1;
         if (accepted) jobQ.delete(0);
         if (jobQ.size() > 0) begin
            bus.job_val    = 1'b1;
            bus.job_header = jobQ[0].header;
            bus.job_target = jobQ[0].target;
            bus.job_id     = jobQ[0].id;
         end else begin
            bus.job_val = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic negSample();
      @(negedge clk);
      #1;
   endtask

   task automatic pushJob(input logic [HEADER_W-1:0] h, input logic [7:0] t, input logic [ID_W-1:0] id);
      job_t j;
      j.header = h;
      j.target = t;
      j.id     = id;
      jobQ.push_back(j);
   endtask

   // which: 0 results, 1 requests, 2 job accepts
   task automatic waitCount(input int which, input int n, input int budget, output bit ok);
      int sz;
      int i = 0;
      sz = (which == 0) ? resLog.size() : (which == 1) ? reqLog.size() : acceptLog.size();
      while (sz < n && i < budget) begin
         negSample();
         i++;
         sz = (which == 0) ? resLog.size() : (which == 1) ? reqLog.size() : acceptLog.size();
      end
      ok = (sz >= n);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      negSample();
      checks++;
      if (bus.job_rdy !== 1'b1 || bus.busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_rdy_busy got job_rdy=%b busy=%b exp job_rdy=1 busy=0", bus.job_rdy, bus.busy);
      end
      checks++;
      if (bus.req_val !== 1'b0 || bus.res_val !== 1'b0 || bus.golden_nonce_rdy !== 1'b0 ||
          bus.jobs_done !== '0 || (|bus.block_header) !== 1'b0 || bus.res_cycles !== '0) begin
         failures++;
         $display("[TB] FAIL reset_outputs got req=%b res=%b gnrdy=%b done=%0d hdr_nz=%b cyc=%0d exp all 0",
                  bus.req_val, bus.res_val, bus.golden_nonce_rdy, bus.jobs_done, |bus.block_header, bus.res_cycles);
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_single_job();
      int nr, nq, na, ng;
      bit ok;
      mDelay = 10;
      mStall = 0;
      mNonce = 32'h0000002A;
      bus.res_rdy = 1'b1;
      nr = resLog.size(); nq = reqLog.size(); na = acceptLog.size(); ng = gnLog.size();
      pushJob('0, 8'd4, 8'h11);
      waitCount(0, nr + 1, 100, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("[TB] FAIL single_timeout got results=%0d exp=%0d", resLog.size() - nr, 1);
      end else begin
         checks++;
         if (resLog[nr].id !== 8'h11 || resLog[nr].nonce !== 32'h2A) begin
            failures++;
            $display("[TB] FAIL single_id_nonce got id=%h nonce=%h exp id=11 nonce=2a", resLog[nr].id, resLog[nr].nonce);
         end
         checks++;
         if (resLog[nr].cycles !== 32'd10) begin
            failures++;
            $display("[TB] FAIL single_cycles got=%0d exp=10", resLog[nr].cycles);
         end
         checks++;
         if (resLog[nr].digest !== (256'h1 << 251)) begin
            failures++;
            $display("[TB] FAIL single_digest got=%h exp=%h", resLog[nr].digest, 256'h1 << 251);
         end
         checks++;
         if (reqLog[nq].edgeNum !== acceptLog[na] + 2) begin
            failures++;
            $display("[TB] FAIL single_req_latency got=%0d exp=%0d", reqLog[nq].edgeNum - acceptLog[na], 2);
         end
         checks++;
         if (resLog[nr].edgeNum !== gnLog[ng] + 1) begin
            failures++;
            $display("[TB] FAIL single_res_latency got=%0d exp=%0d", resLog[nr].edgeNum - gnLog[ng], 1);
         end
         @(posedge clk);
         negSample();
         checks++;
         if (bus.jobs_done !== 32'd1 || bus.busy !== 1'b0 || bus.res_val !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_after got done=%0d busy=%b res_val=%b exp done=1 busy=0 res_val=0",
                     bus.jobs_done, bus.busy, bus.res_val);
         end
      end
   endtask

   task automatic test_back_to_back();
      int nr, nq, na;
      bit ok;
      mDelay = 4;
      mNonce = 32'h55;
      nr = resLog.size(); nq = reqLog.size(); na = acceptLog.size();
      pushJob({19{32'h01010101}}, 8'd1, 8'h01);
      pushJob({19{32'h02020202}}, 8'd2, 8'h02);
      waitCount(2, na + 2, 30, ok);
      @(posedge clk);
      negSample();
      checks++;
      if (!ok || bus.job_rdy !== 1'b0 || bus.busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL b2b_buffered got accepted=%b job_rdy=%b busy=%b exp accepted=1 job_rdy=0 busy=1",
                  ok, bus.job_rdy, bus.busy);
      end
      waitCount(0, nr + 2, 100, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("[TB] FAIL b2b_timeout got results=%0d exp=%0d", resLog.size() - nr, 2);
      end else begin
         checks++;
         if (resLog[nr].id !== 8'h01 || resLog[nr + 1].id !== 8'h02) begin
            failures++;
            $display("[TB] FAIL b2b_order got ids=%h,%h exp 01,02", resLog[nr].id, resLog[nr + 1].id);
         end
         checks++;
         if (reqLog[nq + 1].edgeNum !== resLog[nr].edgeNum + 1 || reqLog[nq + 1].target !== 8'd2) begin
            failures++;
            $display("[TB] FAIL b2b_reissue got gap=%0d target=%0d exp gap=1 target=2",
                     reqLog[nq + 1].edgeNum - resLog[nr].edgeNum, reqLog[nq + 1].target);
         end
         checks++;
         if (resLog[nr + 1].cycles !== 32'd4) begin
            failures++;
            $display("[TB] FAIL b2b_cycles got=%0d exp=4", resLog[nr + 1].cycles);
         end
         @(posedge clk);
         negSample();
         checks++;
         if (bus.jobs_done !== 32'd3) begin
            failures++;
            $display("[TB] FAIL b2b_jobs_done got=%0d exp=3", bus.jobs_done);
         end
      end
   endtask

   task automatic test_req_stall();
      int nr, nq, i, firstEdge;
      bit ok;
      logic [HEADER_W-1:0] hs;
      hs = {19{32'hDEADBEEF}};
      mStall = 5;
      mDelay = 7;
      mNonce = 32'h33;
      nr = resLog.size(); nq = reqLog.size();
      pushJob(hs, 8'd3, 8'h21);
      i = 0;
      negSample();
      while (bus.req_val !== 1'b1 && i < 20) begin
         negSample();
         i++;
      end
      firstEdge = edgeCnt + 1;
      checks++;
      if (bus.req_val !== 1'b1) begin
         failures++;
         $display("[TB] FAIL stall_req_seen got=%b exp=1", bus.req_val);
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (bus.req_val !== 1'b1 || bus.block_header !== hs || bus.hash_target !== 8'd3) begin
            failures++;
            $display("[TB] FAIL stall_hold_%0d got req_val=%b hdr_ok=%b target=%0d exp req_val=1 hdr_ok=1 target=3",
                     k, bus.req_val, bus.block_header === hs, bus.hash_target);
         end
         negSample();
      end
      waitCount(0, nr + 1, 100, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("[TB] FAIL stall_timeout got results=%0d exp=%0d", resLog.size() - nr, 1);
      end else begin
         checks++;
         if (resLog[nr].cycles !== 32'd7 || resLog[nr].id !== 8'h21) begin
            failures++;
            $display("[TB] FAIL stall_result got cycles=%0d id=%h exp cycles=7 id=21", resLog[nr].cycles, resLog[nr].id);
         end
         checks++;
         if (reqLog[nq].edgeNum !== firstEdge + 5 || reqLog[nq].header !== hs) begin
            failures++;
            $display("[TB] FAIL stall_handshake got offset=%0d hdr_ok=%b exp offset=5 hdr_ok=1",
                     reqLog[nq].edgeNum - firstEdge, reqLog[nq].header === hs);
         end
      end
      mStall = 0;
   endtask

   task automatic test_res_backpressure();
      int nr, i;
      bit ok;
      mDelay = 3;
      mNonce = 32'h77;
      tick();
      bus.res_rdy = 1'b0;
      nr = resLog.size();
      pushJob('0, 8'd5, 8'h41);
      pushJob('0, 8'd6, 8'h42);
      pushJob('0, 8'd7, 8'h43);
      i = 0;
      negSample();
      while (bus.res_val !== 1'b1 && i < 50) begin
         negSample();
         i++;
      end
      checks++;
      if (bus.res_val !== 1'b1) begin
         failures++;
         $display("[TB] FAIL bp_res_val got=%b exp=1", bus.res_val);
      end
      for (int k = 0; k < 20; k++) begin
         negSample();
         checks++;
         if (bus.res_val !== 1'b1 || bus.res_id !== 8'h41 || bus.res_nonce !== 32'h77 || bus.res_cycles !== 32'd3 ||
             bus.job_rdy !== 1'b0 || bus.req_val !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_hold_%0d got val=%b id=%h nonce=%h cyc=%0d job_rdy=%b req=%b exp 1,41,77,3,0,0",
                     k, bus.res_val, bus.res_id, bus.res_nonce, bus.res_cycles, bus.job_rdy, bus.req_val);
         end
      end
      checks++;
      if (jobQ.size() !== 1) begin
         failures++;
         $display("[TB] FAIL bp_third_held got pending=%0d exp=1", jobQ.size());
      end
      tick();
      bus.res_rdy = 1'b1;
      waitCount(0, nr + 3, 200, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("[TB] FAIL bp_timeout got results=%0d exp=%0d", resLog.size() - nr, 3);
      end else begin
         checks++;
         if (resLog[nr].id !== 8'h41 || resLog[nr + 1].id !== 8'h42 || resLog[nr + 2].id !== 8'h43 ||
             resLog[nr + 2].digest !== (256'h1 << 248)) begin
            failures++;
            $display("[TB] FAIL bp_order got ids=%h,%h,%h digest3=%h exp 41,42,43 digest3=%h",
                     resLog[nr].id, resLog[nr + 1].id, resLog[nr + 2].id, resLog[nr + 2].digest, 256'h1 << 248);
         end
      end
   endtask

   task automatic test_reset_mid();
      int nr, nq, na;
      bit ok, ok2;
      mDelay = 40;
      mNonce = 32'h99;
      bus.res_rdy = 1'b1;
      nq = reqLog.size(); na = acceptLog.size();
      pushJob('0, 8'd4, 8'h51);
      pushJob('0, 8'd5, 8'h52);
      waitCount(1, nq + 1, 30, ok);
      waitCount(2, na + 2, 30, ok2);
      @(posedge clk);
      negSample();
      checks++;
      if (!ok || !ok2 || bus.job_rdy !== 1'b0 || bus.golden_nonce_rdy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL rstmid_setup got req=%b acc=%b job_rdy=%b gnrdy=%b exp 1,1,0,1",
                  ok, ok2, bus.job_rdy, bus.golden_nonce_rdy);
      end
      nr = resLog.size();
      nq = reqLog.size();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      negSample();
      checks++;
      if (bus.job_rdy !== 1'b1 || bus.busy !== 1'b0 || bus.req_val !== 1'b0 || bus.res_val !== 1'b0 ||
          bus.golden_nonce_rdy !== 1'b0 || bus.jobs_done !== '0 || (|bus.block_header) !== 1'b0 ||
          bus.hash_target !== '0 || bus.res_id !== '0 || bus.res_nonce !== '0 || (|bus.res_digest) !== 1'b0 ||
          bus.res_cycles !== '0) begin
         failures++;
         $display("[TB] FAIL rstmid_outputs got job_rdy=%b busy=%b req=%b res=%b gnrdy=%b done=%0d tgt=%0d id=%h exp job_rdy=1 rest 0",
                  bus.job_rdy, bus.busy, bus.req_val, bus.res_val, bus.golden_nonce_rdy, bus.jobs_done,
                  bus.hash_target, bus.res_id);
      end
      tick();
      tLateGnv = 1'b1;
      for (int k = 0; k < 6; k++) begin
         negSample();
         checks++;
         if (bus.res_val !== 1'b0 || bus.golden_nonce_rdy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_late_gnv_%0d got res_val=%b gnrdy=%b exp 0,0", k, bus.res_val, bus.golden_nonce_rdy);
         end
      end
      tick();
      tLateGnv = 1'b0;
      repeat (50) tick();
      checks++;
      if (resLog.size() !== nr || reqLog.size() !== nq) begin
         failures++;
         $display("[TB] FAIL rstmid_discarded got new_results=%0d new_reqs=%0d exp 0,0",
                  resLog.size() - nr, reqLog.size() - nq);
      end
   endtask

   task automatic test_multi_target();
      int nr;
      bit ok;
      logic [7:0] tg [3];
      tg[0] = 8'd4; tg[1] = 8'd8; tg[2] = 8'd12;
      mDelay = 6;
      mNonce = 32'h1234;
      nr = resLog.size();
      for (int k = 0; k < 3; k++) pushJob('0, tg[k], 8'(8'h61 + k));
      waitCount(0, nr + 3, 300, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("[TB] FAIL multi_timeout got results=%0d exp=%0d", resLog.size() - nr, 3);
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (resLog[nr + k].id !== 8'(8'h61 + k) || (resLog[nr + k].digest >> (256 - int'(tg[k]))) !== '0 ||
                resLog[nr + k].digest !== (256'h1 << (255 - int'(tg[k]))) || resLog[nr + k].nonce !== 32'h1234) begin
               failures++;
               $display("[TB] FAIL multi_result_%0d got id=%h nonce=%h digest=%h exp id=%h nonce=1234 digest=%h",
                        k, resLog[nr + k].id, resLog[nr + k].nonce, resLog[nr + k].digest,
                        8'(8'h61 + k), 256'h1 << (255 - int'(tg[k])));
            end
         end
         @(posedge clk);
         negSample();
         checks++;
         if (bus.jobs_done !== 32'd3) begin
            failures++;
            $display("[TB] FAIL multi_jobs_done got=%0d exp=3", bus.jobs_done);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      mDelay   = 10;
      mStall   = 0;
      mNonce   = '0;
      tLateGnv = 1'b0;
      bus.res_rdy = 1'b0;
      test_reset();
      test_single_job();
      test_back_to_back();
      test_req_stall();
      test_res_backpressure();
      test_reset_mid();
      test_multi_target();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
